// File: rtl/xy_out_port_arbiter_pkg.sv
// Shared definitions for the XY mesh output-port arbiter: port indices,
// FSM state encoding and packet width derivation.
package xy_out_port_arbiter_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  // A packet carries data followed by one X and one Y coordinate.
  function automatic int pckt_width(input int data_w, input int addr_w);
    return data_w + 2 * addr_w;
  endfunction

  localparam int PORT_N_DEF = 5;
  localparam int PCKT_W_DEF = pckt_width(DATA_W, ADDR_W);

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_LEFT  = 3'd1;
  localparam logic [2:0] PORT_UP    = 3'd2;
  localparam logic [2:0] PORT_RIGHT = 3'd3;
  localparam logic [2:0] PORT_DOWN  = 3'd4;

  typedef enum logic {
    ARB  = 1'b0,
    HALT = 1'b1
  } arb_state_e;

  function automatic logic [15:0] cnt_inc(input logic [15:0] cnt, input logic en);
    return cnt + {15'd0, en};
  endfunction

endpackage

// File: rtl/xy_out_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after ptr_i, wrapping
// modulo N. Shared between the output-port and input-side arbiters.
module xy_out_port_arbiter_rr_pick #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             vld_o
);

  logic [N-1:0]     gnt_v;
  logic [PTR_W-1:0] idx_v;
  logic [PTR_W-1:0] cand_v;
  logic             found_v;
  logic             hit_v;
  int               cand_i;

  // Scan ptr+1 .. ptr+N; the first hit wins and masks all later candidates.
  always_comb begin
    gnt_v   = '0;
    idx_v   = '0;
    cand_v  = '0;
    found_v = 1'b0;
    hit_v   = 1'b0;
    cand_i  = 0;
    for (int k = 1; k <= N; k++) begin
      cand_i        = (int'(ptr_i) + k) % N;
      cand_v        = PTR_W'(cand_i);
      hit_v         = req_i[cand_v] & ~found_v;
      gnt_v[cand_v] = gnt_v[cand_v] | hit_v;
      idx_v         = hit_v ? cand_v : idx_v;
      found_v       = found_v | hit_v;
    end
    gnt_o = gnt_v;
    idx_o = idx_v;
    vld_o = found_v;
  end

endmodule

// File: rtl/xy_out_port_arbiter.sv
// Round-robin arbiter for one XY switch output port. Pops the winning input
// FIFO and forwards its head packet downstream; halts on downstream overflow.
module xy_out_port_arbiter
  import xy_out_port_arbiter_pkg::*;
#(
  parameter int PORT_N = PORT_N_DEF,
  parameter int PCKT_W = PCKT_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PORT_N-1:0]        req_i,
  input  logic [PORT_N*PCKT_W-1:0] pckt_i,
  output logic [PORT_N-1:0]        rd_en_o,
  input  logic                     nxt_full_i,
  input  logic                     nxt_ovrflw_i,
  output logic                     wr_en_o,
  output logic [PCKT_W-1:0]        pckt_o,
  input  logic                     clr_i,
  output logic                     halt_o,
  output logic [15:0]              grant_cnt_o
);

  localparam int PTR_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(PORT_N - 1);

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PCKT_W-1:0]   pckt_q, pckt_d;
  logic                wr_en_q, wr_en_d;
  logic                halt_q, halt_d;
  logic [15:0]         grant_cnt_q, grant_cnt_d;

  logic [PORT_N-1:0]   pick_gnt_s;
  logic [PTR_W-1:0]    pick_idx_s;
  logic                pick_vld_s;
  logic                grant_s;
  logic [PCKT_W-1:0]   win_pckt_s;

  xy_out_port_arbiter_rr_pick #(
    .N     (PORT_N),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .vld_o (pick_vld_s)
  );

  // Grant decision, winner mux and next-state for every register.
  always_comb begin
    grant_s = (state_q == ARB) & pick_vld_s & ~nxt_full_i & ~rst_i;
    rd_en_o = grant_s ? pick_gnt_s : '0;

    win_pckt_s = '0;
    for (int i = 0; i < PORT_N; i++) begin
      win_pckt_s = win_pckt_s | ({PCKT_W{pick_gnt_s[i]}} & pckt_i[i*PCKT_W +: PCKT_W]);
    end

    // Overflow seen in HALT is ignored; clr is only meaningful in HALT.
    case (state_q)
      ARB:     state_d = nxt_ovrflw_i ? HALT : ARB;
      HALT:    state_d = clr_i ? ARB : HALT;
      default: state_d = ARB;
    endcase
    halt_d = (state_d == HALT);

    if (grant_s) begin
      wr_en_d  = 1'b1;
      pckt_d   = win_pckt_s;
      rr_ptr_d = pick_idx_s;
    end else begin
      wr_en_d  = 1'b0;
      pckt_d   = pckt_q;
      rr_ptr_d = rr_ptr_q;
    end
    grant_cnt_d = cnt_inc(grant_cnt_q, grant_s);
  end

  // State and output registers; reset wins over any in-flight transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB;
      rr_ptr_q    <= PTR_RST;
      pckt_q      <= '0;
      wr_en_q     <= 1'b0;
      halt_q      <= 1'b0;
      grant_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      pckt_q      <= pckt_d;
      wr_en_q     <= wr_en_d;
      halt_q      <= halt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign pckt_o      = pckt_q;
  assign halt_o      = halt_q;
  assign grant_cnt_o = grant_cnt_q;

endmodule

// File: tb/tb_xy_out_port_arbiter.sv
// Bench for xy_out_port_arbiter: directed vector table followed by a
// randomized run against a priority-queue reference model.
module tb_xy_out_port_arbiter;

  localparam int N = 5;
  localparam int W = 12;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   pckt_i;
  logic [N-1:0]     rd_en_o;
  logic             nxt_full_i;
  logic             nxt_ovrflw_i;
  logic             wr_en_o;
  logic [W-1:0]     pckt_o;
  logic             clr_i;
  logic             halt_o;
  logic [15:0]      grant_cnt_o;

  always #5 clk_i = ~clk_i;

  xy_out_port_arbiter #(.PORT_N(N), .PCKT_W(W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .pckt_i       (pckt_i),
    .rd_en_o      (rd_en_o),
    .nxt_full_i   (nxt_full_i),
    .nxt_ovrflw_i (nxt_ovrflw_i),
    .wr_en_o      (wr_en_o),
    .pckt_o       (pckt_o),
    .clr_i        (clr_i),
    .halt_o       (halt_o),
    .grant_cnt_o  (grant_cnt_o)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [W-1:0] base;
    logic         full;
    logic         ovf;
    logic         clr;
    logic [N-1:0] e_rd;
    logic         e_wr;
    logic [W-1:0] e_pckt;
    logic         e_halt;
    logic [15:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic [N-1:0] req, input logic [W-1:0] base,
                              input logic full, input logic ovf, input logic clr,
                              input logic [N-1:0] e_rd, input logic e_wr, input logic [W-1:0] e_pckt,
                              input logic e_halt, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.base = base; v.full = full; v.ovf = ovf; v.clr = clr;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_pckt = e_pckt; v.e_halt = e_halt; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  // Slice i of the packet bus carries base+i, so the forwarded value names its port.
  function automatic logic [N*W-1:0] mk_pk(input logic [W-1:0] base);
    logic [N*W-1:0] pk;
    pk = '0;
    for (int i = 0; i < N; i++) pk[i*W +: W] = base + W'(i);
    return pk;
  endfunction

  task automatic drive(input logic rst, input logic [N-1:0] req, input logic [N*W-1:0] pk,
                       input logic full, input logic ovf, input logic clr);
    @(negedge clk_i);
    rst_i = rst; req_i = req; pckt_i = pk;
    nxt_full_i = full; nxt_ovrflw_i = ovf; clr_i = clr;
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic e_wr, input logic [W-1:0] e_pckt,
                          input logic e_halt, input logic [15:0] e_cnt);
    chk({tag, " wr_en"}, 32'(wr_en_o), 32'(e_wr));
    chk({tag, " pckt"},  32'(pckt_o),  32'(e_pckt));
    chk({tag, " halt"},  32'(halt_o),  32'(e_halt));
    chk({tag, " cnt"},   32'(grant_cnt_o), 32'(e_cnt));
  endtask

  // Reference model: ports kept in current priority order.
  int           prio_q[$];
  logic         m_halt;
  logic         m_wr;
  logic [W-1:0] m_pckt;
  logic [15:0]  m_cnt;

  initial begin
    vec_t         v;
    logic [N-1:0] req, e_rd;
    logic [N*W-1:0] pk;
    logic         rst, full, ovf, clr;
    int           win, jsel;

    rst_i = 1'b1; req_i = '0; pckt_i = '0;
    nxt_full_i = 1'b0; nxt_ovrflw_i = 1'b0; clr_i = 1'b0;

    // Reset, then a single request from port 2.
    add(1'b1, 5'h1F, 12'h000, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 12'h000, 1'b0, 16'd0);
    add(1'b0, 5'h04, 12'hA5A, 1'b0, 1'b0, 1'b0, 5'h04, 1'b1, 12'hA5C, 1'b0, 16'd1);
    add(1'b0, 5'h00, 12'hA5A, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 12'hA5C, 1'b0, 16'd1);
    // All requesting after reset: strict 0..4 rotation, twice.
    add(1'b1, 5'h1F, 12'h000, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 12'h000, 1'b0, 16'd0);
    for (int k = 0; k < 10; k++)
      add(1'b0, 5'h1F, W'(256 * k), 1'b0, 1'b0, 1'b0, N'(1 << (k % 5)), 1'b1,
          W'(256 * k + k % 5), 1'b0, 16'(k + 1));
    // Back-pressure in relative cycles 3..6; last winner was 4.
    add(1'b0, 5'h1F, 12'hB00, 1'b0, 1'b0, 1'b0, 5'h01, 1'b1, 12'hB00, 1'b0, 16'd11);
    add(1'b0, 5'h1F, 12'hB10, 1'b0, 1'b0, 1'b0, 5'h02, 1'b1, 12'hB11, 1'b0, 16'd12);
    add(1'b0, 5'h1F, 12'hB20, 1'b0, 1'b0, 1'b0, 5'h04, 1'b1, 12'hB22, 1'b0, 16'd13);
    for (int k = 3; k < 7; k++)
      add(1'b0, 5'h1F, W'(12'hB00 + 16 * k), 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 12'hB22, 1'b0, 16'd13);
    add(1'b0, 5'h1F, 12'hB70, 1'b0, 1'b0, 1'b0, 5'h08, 1'b1, 12'hB73, 1'b0, 16'd14);
    // Wrap with pointer at 3 and only ports 0,1 requesting.
    add(1'b0, 5'h03, 12'hC00, 1'b0, 1'b0, 1'b0, 5'h01, 1'b1, 12'hC00, 1'b0, 16'd15);
    add(1'b0, 5'h03, 12'hC10, 1'b0, 1'b0, 1'b0, 5'h02, 1'b1, 12'hC11, 1'b0, 16'd16);
    add(1'b0, 5'h03, 12'hC20, 1'b0, 1'b0, 1'b0, 5'h01, 1'b1, 12'hC20, 1'b0, 16'd17);
    // Overflow with a grant, ignored overflow in HALT, clr beats overflow, clr in ARB.
    add(1'b0, 5'h1F, 12'hD00, 1'b0, 1'b1, 1'b0, 5'h02, 1'b1, 12'hD01, 1'b1, 16'd18);
    add(1'b0, 5'h1F, 12'hD10, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 12'hD01, 1'b1, 16'd18);
    add(1'b0, 5'h1F, 12'hD20, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 12'hD01, 1'b1, 16'd18);
    add(1'b0, 5'h1F, 12'hD30, 1'b0, 1'b1, 1'b1, 5'h00, 1'b0, 12'hD01, 1'b0, 16'd18);
    add(1'b0, 5'h1F, 12'hD40, 1'b0, 1'b0, 1'b0, 5'h04, 1'b1, 12'hD42, 1'b0, 16'd19);
    add(1'b0, 5'h1F, 12'hD50, 1'b0, 1'b0, 1'b1, 5'h08, 1'b1, 12'hD53, 1'b0, 16'd20);
    // Reset in the middle of a stream, then restart at port 0.
    add(1'b1, 5'h1F, 12'hD60, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 12'h000, 1'b0, 16'd0);
    add(1'b0, 5'h1F, 12'hD70, 1'b0, 1'b0, 1'b0, 5'h01, 1'b1, 12'hD70, 1'b0, 16'd1);

    foreach (vecs[k]) begin
      v = vecs[k];
      drive(v.rst, v.req, mk_pk(v.base), v.full, v.ovf, v.clr);
      chk($sformatf("vec%0d rd_en", k), 32'(rd_en_o), 32'(v.e_rd));
      @(posedge clk_i); #1;
      chk_regs($sformatf("vec%0d", k), v.e_wr, v.e_pckt, v.e_halt, v.e_cnt);
    end

    // Randomized run against the model.
    prio_q = {0, 1, 2, 3, 4};
    m_halt = 1'b0; m_wr = 1'b0; m_pckt = '0; m_cnt = 16'd0;
    for (int c = 0; c < 3000; c++) begin
      rst  = (c == 0) || ($urandom_range(0, 149) == 0);
      req  = N'($urandom);
      full = ($urandom_range(0, 3) == 0);
      ovf  = ($urandom_range(0, 39) == 0);
      clr  = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < N; i++) pk[i*W +: W] = W'($urandom);

      e_rd = '0;
      win  = -1;
      jsel = -1;
      if (!rst && !m_halt && req != '0 && !full) begin
        for (int j = 0; j < N; j++)
          if (jsel < 0 && req[prio_q[j]]) jsel = j;
        win = prio_q[jsel];
        e_rd[win] = 1'b1;
        for (int r = 0; r <= jsel; r++) prio_q.push_back(prio_q.pop_front());
      end

      drive(rst, req, pk, full, ovf, clr);
      chk($sformatf("rnd%0d rd_en", c), 32'(rd_en_o), 32'(e_rd));

      if (rst) begin
        prio_q = {0, 1, 2, 3, 4};
        m_halt = 1'b0; m_wr = 1'b0; m_pckt = '0; m_cnt = 16'd0;
      end else begin
        m_wr = (win >= 0);
        if (win >= 0) begin
          m_pckt = pk[win*W +: W];
          m_cnt  = m_cnt + 16'd1;
        end
        if (m_halt) m_halt = !clr;
        else        m_halt = ovf;
      end

      @(posedge clk_i); #1;
      chk_regs($sformatf("rnd%0d", c), m_wr, m_pckt, m_halt, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xy_out_port_arbiter.md
Name: xy_out_port_arbiter

Overview:
- Per-output-port round-robin arbiter for the XY mesh switch. One instance is placed per switch output port: local resource, LEFT, UP, RIGHT and DOWN.
- Shares its output link among the PORT_N input FIFOs that route to it. It pops the winning FIFO and drives a registered packet plus write-enable to the neighbour FIFO or the resource.
- Honours downstream full back-pressure. Latches downstream overflow as a sticky error and halts the port until software clears it.

Parameters:
- PORT_N, 5, number of requesting input ports; port 0 is the local resource.
- PCKT_W, 12, packet width in bits (data plus X address plus Y address).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  PORT_N  bit i: input FIFO i is non-empty and its head packet routes to this output. FIFOs are first-word-fall-through.
- pckt_i  in  PORT_N*PCKT_W  head packets; slice i is [PCKT_W*(i+1)-1 : PCKT_W*i].
- rd_en_o  out  PORT_N  one-hot pop strobe to the granted input FIFO; combinational.
- nxt_full_i  in  1  downstream FIFO full.
- nxt_ovrflw_i  in  1  downstream FIFO overflow.
- wr_en_o  out  1  registered write strobe to the downstream FIFO.
- pckt_o  out  PCKT_W  registered packet to the downstream FIFO.
- clr_i  in  1  clears a halt and the error flag.
- halt_o  out  1  registered; high while in HALT.
- grant_cnt_o  out  16  registered; count of packets forwarded, wraps at 2^16.

Behaviour:
- Reset (rst_i=1 at an edge): wr_en_o=0, pckt_o=0, halt_o=0, grant_cnt_o=0, rr_ptr=PORT_N-1, state=ARB. rd_en_o=0 while rst_i=1. Reset overrides every event in the same cycle, including mid-transfer: a pending wr_en_o is dropped and no packet is lost from a FIFO, because no pop occurs under reset.
- FSM states:
  - ARB: normal arbitration.
  - HALT: no grants. Entered on the edge after nxt_ovrflw_i=1 is sampled in ARB.
  - HALT -> ARB on the edge where clr_i=1. rr_ptr is preserved across the halt.
  - clr_i in ARB has no effect.
- Grant condition, evaluated each cycle in ARB: grant if |req_i && !nxt_full_i && !rst_i.
- Winner selection: first index with req set, searching rr_ptr+1, rr_ptr+2, … modulo PORT_N. The search wraps from PORT_N-1 to 0.
- On a grant in cycle N:
  - rd_en_o[winner]=1 in cycle N, combinationally, exactly one bit.
  - At the edge ending cycle N: pckt_o <= pckt_i slice[winner], wr_en_o <= 1, rr_ptr <= winner, grant_cnt_o increments.
  - Latency is 1 cycle from req_i to wr_en_o. Sustained throughput is 1 packet per cycle.
- No grant in a cycle: wr_en_o <= 0 at the next edge, pckt_o holds its value, rr_ptr holds.
- Back-pressure: nxt_full_i is sampled in the grant cycle. The downstream FIFO must tolerate the one write already in flight when full rises; this is consistent with its overflow flag.
- Simultaneous nxt_ovrflw_i and a grant condition in ARB: the grant still happens in that cycle, then the FSM goes to HALT.
- nxt_ovrflw_i while in HALT: ignored.
- nxt_ovrflw_i and clr_i in the same HALT cycle: clr wins and the FSM returns to ARB.
- Requesters never receive rd_en_o unless req_i is set. A req_i that drops mid-cycle carries no obligation.
- Fairness: with all PORT_N requesting continuously, each port is granted exactly once per PORT_N consecutive grants.

Decomposition:
- Shared package/header: port index constants (LOCAL=0, LEFT=1, UP=2, RIGHT=3, DOWN=4) and the FSM state encoding (ARB=0, HALT=1). The PCKT_W derivation macro comes from the same header.
- One sub-module, rr_pick: combinational round-robin selector. Inputs are req and ptr; outputs are a one-hot grant and a binary index. It is reused by the future input-side arbiter.

Test Plan:
- Single request: req_i=5'b00100, pckt slice2=12'hA5C, full=0 -> rd_en_o=5'b00100 in cycle N; wr_en_o=1 and pckt_o=12'hA5C in cycle N+1; grant_cnt_o=1.
- All request after reset, held 10 cycles, distinct packets -> grant order 0,1,2,3,4,0,1,2,3,4; wr_en_o high for 10 consecutive cycles.
- Back-pressure: all requesting, nxt_full_i=1 for cycles 3–6 -> rd_en_o=0 in cycles 3–6; wr_en_o=0 in cycles 4–7; rotation resumes at the next index after the last winner.
- Overflow halt: pulse nxt_ovrflw_i in cycle 5 with req active -> grant in cycle 5; halt_o=1 from cycle 6; no rd_en_o until clr_i=1 in cycle 9; grants resume in cycle 10 from rr_ptr+1.
- Wrap: rr_ptr=3, req_i=5'b00011 -> winner 0 next, then 1, then 0.
- Reset mid-stream: rst_i=1 during continuous grants -> next cycle wr_en_o=0, pckt_o=0, grant_cnt_o=0; after release, first grant goes to port 0.
